// File: rtl/pcs_loopback_fifo.sv
// pcs_loopback_fifo
// Elastic buffer between a PCS receive path and a PCS transmit path. It
// deletes idles near the high watermark, counts overflow and underrun, and
// uses a small frame FSM on the read side. The read side inserts idles between
// frames and emits an error block when a frame is cut short.
module pcs_loopback_fifo #(
  parameter int IS_10G = 1,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int HI_WM  = DEPTH - 2,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             rx_signal_v_i,
  input  logic                             rx_valid_i,
  input  logic                             rx_ctrl_i,
  input  logic                             rx_idle_i,
  input  logic                             rx_term_i,
  input  logic                             rx_err_i,
  input  logic [(IS_10G != 0 ? 2 : 1)-1:0] rx_start_i,
  input  logic [DATA_W/8-1:0]              rx_keep_i,
  input  logic [DATA_W-1:0]                rx_data_i,
  input  logic                             tx_ready_i,
  output logic                             tx_ctrl_o,
  output logic                             tx_idle_o,
  output logic                             tx_term_o,
  output logic                             tx_err_o,
  output logic [(IS_10G != 0 ? 2 : 1)-1:0] tx_start_o,
  output logic [DATA_W/8-1:0]              tx_keep_o,
  output logic [DATA_W-1:0]                tx_data_o,
  output logic [$clog2(DEPTH):0]           level_o,
  output logic [CNT_W-1:0]                 idle_del_cnt_o,
  output logic [CNT_W-1:0]                 idle_ins_cnt_o,
  output logic [CNT_W-1:0]                 ovf_cnt_o,
  output logic [CNT_W-1:0]                 unf_cnt_o,
  output logic                             ovf_sticky_o,
  output logic                             unf_sticky_o
);

  localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1;
  localparam int KEEP_W      = DATA_W / 8;
  localparam int AW          = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] HI_WM_L = (AW+1)'(HI_WM);

  typedef struct packed {
    logic                   ctrl;
    logic                   idle;
    logic [LANE0_CNT_N-1:0] start;
    logic                   term;
    logic                   err;
    logic [KEEP_W-1:0]      keep;
    logic [DATA_W-1:0]      data;
  } entry_t;

  typedef enum logic [1:0] {IDLE_S, FRAME_S, DROP_S} state_t;

  entry_t      mem [DEPTH];
  entry_t      rx_entry, head, tx_q, tx_nxt;
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        empty, full, pop_en, advance, pop;
  logic        push_cand, idle_drop, ovf_drop, push;
  logic        inc_ins, inc_unf;
  state_t      state, state_nxt;

  // Build a control-only block (idle or error); every other field is zero.
  function automatic entry_t ctrl_blk(input logic idle, input logic err);
    entry_t b;
    b      = '0;
    b.ctrl = 1'b1;
    b.idle = idle;
    b.err  = err;
    return b;
  endfunction

  // Increment a statistics counter without wrapping past all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign rx_entry = {rx_ctrl_i, rx_idle_i, rx_start_i, rx_term_i, rx_err_i, rx_keep_i, rx_data_i};
  assign head     = mem[rd_ptr[AW-1:0]];

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The read side stays frozen for the first cycle after reset release.
  assign advance = pop_en & tx_ready_i;
  assign pop     = advance & ~empty;

  assign push_cand = rx_signal_v_i & rx_valid_i;
  assign idle_drop = push_cand & rx_ctrl_i & rx_idle_i & (level >= HI_WM_L);
  assign ovf_drop  = push_cand & ~idle_drop & full & ~pop;
  assign push      = push_cand & ~idle_drop & ~ovf_drop;

  // Pointer and read-enable registers.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pop_en <= 1'b0;
    end else begin
      pop_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; occupancy comes only from the pointers, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_entry;
  end

  // Frame FSM state register; only moves on cycles where a block is emitted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE_S;
    else         state <= state_nxt;
  end

  // Frame FSM next-state decode.
  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (advance) begin
      unique case (state)
        IDLE_S: begin
          if (!empty && (|head.start) && !head.term) state_nxt = FRAME_S;
        end
        FRAME_S: begin
          if (empty)          state_nxt = DROP_S;
          else if (head.term) state_nxt = IDLE_S;
        end
        DROP_S: begin
          if (!empty) begin
            if (|head.start) state_nxt = head.term ? IDLE_S : FRAME_S;
            else if (head.term) state_nxt = IDLE_S;
          end
        end
        default: state_nxt = IDLE_S;
      endcase
    end
  end

  // Frame FSM output decode: the next TX block and statistics strobes.
  always_comb begin
    tx_nxt  = ctrl_blk(1'b1, 1'b0);
    inc_ins = 1'b0;
    inc_unf = 1'b0;
    unique case (state)
      IDLE_S: begin
        if (empty) inc_ins = advance;
        else       tx_nxt  = head;
      end
      FRAME_S: begin
        if (empty) begin
          tx_nxt  = ctrl_blk(1'b0, 1'b1);
          inc_unf = advance;
        end else begin
          tx_nxt = head;
          // A start inside an open frame means the previous frame lost its term.
          if (|head.start) tx_nxt.err = 1'b1;
        end
      end
      DROP_S: begin
        if (!empty && (|head.start)) tx_nxt = head;
      end
      default: tx_nxt = ctrl_blk(1'b1, 1'b0);
    endcase
  end

  // Registered TX block; holds while the transmitter is not ready.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      tx_q <= ctrl_blk(1'b1, 1'b0);
    else if (advance) tx_q <= tx_nxt;
  end

  // Saturating statistics counters and sticky error flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idle_del_cnt_o <= '0;
      idle_ins_cnt_o <= '0;
      ovf_cnt_o      <= '0;
      unf_cnt_o      <= '0;
      ovf_sticky_o   <= 1'b0;
      unf_sticky_o   <= 1'b0;
    end else begin
      idle_del_cnt_o <= sat_inc(idle_del_cnt_o, idle_drop);
      idle_ins_cnt_o <= sat_inc(idle_ins_cnt_o, inc_ins);
      ovf_cnt_o      <= sat_inc(ovf_cnt_o, ovf_drop);
      unf_cnt_o      <= sat_inc(unf_cnt_o, inc_unf);
      ovf_sticky_o   <= ovf_sticky_o | ovf_drop;
      unf_sticky_o   <= unf_sticky_o | inc_unf;
    end
  end

  assign tx_ctrl_o  = tx_q.ctrl;
  assign tx_idle_o  = tx_q.idle;
  assign tx_start_o = tx_q.start;
  assign tx_term_o  = tx_q.term;
  assign tx_err_o   = tx_q.err;
  assign tx_keep_o  = tx_q.keep;
  assign tx_data_o  = tx_q.data;
  assign level_o    = level;

endmodule

// File: tb/tb_pcs_loopback_fifo.sv
// Testbench for pcs_loopback_fifo: directed vector tables plus short
// hand-written sequences for idle deletion, overflow, underrun, counter
// saturation and reset in the middle of a frame.
module tb_pcs_loopback_fifo;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int LN     = 2;
  localparam int DEPTH  = 8;
  localparam int HI_WM  = 6;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              ctrl;
    logic              idle;
    logic [LN-1:0]     start;
    logic              term;
    logic              err;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } blk_t;

  typedef struct {
    logic       valid;
    logic       ready;
    blk_t       in;
    blk_t       exp;
    logic [3:0] exp_level;
  } vec_t;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic rx_signal_v, rx_valid, tx_ready;
  blk_t rx, tx;
  logic tx_ctrl, tx_idle, tx_term, tx_err;
  logic [LN-1:0]     tx_start;
  logic [KEEP_W-1:0] tx_keep;
  logic [DATA_W-1:0] tx_data;
  logic [3:0]        level;
  logic [CNT_W-1:0]  idle_del_cnt, idle_ins_cnt, ovf_cnt, unf_cnt;
  logic              ovf_sticky, unf_sticky;

  int n_vec = 0;
  int n_err = 0;

  pcs_loopback_fifo #(
    .IS_10G(1), .DATA_W(DATA_W), .DEPTH(DEPTH), .HI_WM(HI_WM), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .rx_signal_v_i  (rx_signal_v),
    .rx_valid_i     (rx_valid),
    .rx_ctrl_i      (rx.ctrl),
    .rx_idle_i      (rx.idle),
    .rx_term_i      (rx.term),
    .rx_err_i       (rx.err),
    .rx_start_i     (rx.start),
    .rx_keep_i      (rx.keep),
    .rx_data_i      (rx.data),
    .tx_ready_i     (tx_ready),
    .tx_ctrl_o      (tx_ctrl),
    .tx_idle_o      (tx_idle),
    .tx_term_o      (tx_term),
    .tx_err_o       (tx_err),
    .tx_start_o     (tx_start),
    .tx_keep_o      (tx_keep),
    .tx_data_o      (tx_data),
    .level_o        (level),
    .idle_del_cnt_o (idle_del_cnt),
    .idle_ins_cnt_o (idle_ins_cnt),
    .ovf_cnt_o      (ovf_cnt),
    .unf_cnt_o      (unf_cnt),
    .ovf_sticky_o   (ovf_sticky),
    .unf_sticky_o   (unf_sticky)
  );

  assign tx = {tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic blk_t idle_blk();
    blk_t b = '0;
    b.ctrl = 1'b1;
    b.idle = 1'b1;
    return b;
  endfunction

  function automatic blk_t err_blk();
    blk_t b = '0;
    b.ctrl = 1'b1;
    b.err  = 1'b1;
    return b;
  endfunction

  function automatic blk_t start_blk(input logic [7:0] tag);
    blk_t b = '0;
    b.ctrl  = 1'b1;
    b.start = 2'b01;
    b.keep  = 8'hFF;
    b.data  = {tag, 56'h55_5555_5555_55FB};
    return b;
  endfunction

  function automatic blk_t data_blk(input logic [7:0] tag, input int i);
    blk_t b = '0;
    b.keep = 8'hFF;
    b.data = {tag, 8'(i), 48'hDA7A_C0DE_BEEF};
    return b;
  endfunction

  function automatic blk_t term_blk(input logic [7:0] tag);
    blk_t b = '0;
    b.ctrl = 1'b1;
    b.term = 1'b1;
    b.keep = 8'h0F;
    b.data = {tag, 56'h07_0707_07FD_1122};
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset      = 1'b0;
    rx_signal_v = 1'b1;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
    rx          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string name);
    rx_valid = v.valid;
    tx_ready = v.ready;
    rx       = v.in;
    step();
    check({name, "_tx"}, 128'(tx), 128'(v.exp));
    check({name, "_level"}, 128'(level), 128'(v.exp_level));
  endtask

  task automatic check_counters(input string name, input int del, input int ins, input int ovf, input int unf);
    check({name, "_idle_del"}, 128'(idle_del_cnt), 128'(del));
    check({name, "_idle_ins"}, 128'(idle_ins_cnt), 128'(ins));
    check({name, "_ovf"}, 128'(ovf_cnt), 128'(ovf));
    check({name, "_unf"}, 128'(unf_cnt), 128'(unf));
  endtask

  blk_t frame[10];
  vec_t pt[11];
  vec_t ur[13];
  blk_t sb[$];
  blk_t b, e;
  int   max_lvl, ph;

  // Frame scoreboard: every non-idle block leaving TX must match the next frame block sent.
  task automatic mon();
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (tx_ready && !(tx.ctrl && tx.idle)) begin
      if (sb.size() == 0) check("idel_extra_blk", 128'(tx), 128'(idle_blk()));
      else                check("idel_frame_blk", 128'(tx), 128'(sb.pop_front()));
    end
  endtask

  initial begin
    do_reset();
    check("reset_tx", 128'(tx), 128'(idle_blk()));
    check("reset_level", 128'(level), 128'(0));
    check_counters("reset", 0, 0, 0, 0);

    // Passthrough: 10-block frame, TX always ready, one cycle of latency.
    frame[0] = start_blk(8'h11);
    for (int i = 1; i <= 8; i++) frame[i] = data_blk(8'h11, i);
    frame[9] = term_blk(8'h11);
    for (int i = 0; i < 11; i++) begin
      pt[i].valid     = (i < 10);
      pt[i].ready     = 1'b1;
      pt[i].in        = (i < 10) ? frame[i] : '0;
      pt[i].exp       = (i == 0) ? idle_blk() : frame[i-1];
      pt[i].exp_level = (i == 10) ? 4'd0 : 4'd1;
    end
    for (int i = 0; i < 11; i++) apply(pt[i], $sformatf("pt%0d", i));
    check_counters("pt", 0, 0, 0, 0);
    check("pt_ovf_sticky", 128'(ovf_sticky), 128'(0));
    check("pt_unf_sticky", 128'(unf_sticky), 128'(0));

    // Idle deletion: TX stalls one cycle in 33 while RX streams idles and frames.
    do_reset();
    max_lvl = 0;
    sb.delete();
    for (int c = 0; c < 330; c++) begin
      ph       = c % 33;
      tx_ready = (ph != 0);
      rx_valid = 1'b1;
      if (ph >= 20 && ph <= 25) begin
        if (ph == 20)      b = start_blk(8'(c / 33));
        else if (ph == 25) b = term_blk(8'(c / 33));
        else               b = data_blk(8'(c / 33), ph - 20);
        sb.push_back(b);
      end else begin
        b = idle_blk();
      end
      rx = b;
      step();
      mon();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (10) begin
      step();
      mon();
    end
    check("idel_frames_left", 128'(sb.size()), 128'(0));
    check("idel_max_level", 128'(max_lvl), 128'(HI_WM));
    check("idel_del_nonzero", 128'(idle_del_cnt != 0), 128'(1));
    check("idel_ovf", 128'(ovf_cnt), 128'(0));
    check("idel_unf", 128'(unf_cnt), 128'(0));

    // Overflow: TX stalled, nine data blocks into eight entries.
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx = data_blk(8'h0F, i);
      step();
    end
    check("ovf_level", 128'(level), 128'(8));
    check("ovf_cnt", 128'(ovf_cnt), 128'(1));
    check("ovf_sticky", 128'(ovf_sticky), 128'(1));
    check("ovf_idle_del", 128'(idle_del_cnt), 128'(0));
    check("ovf_tx_held", 128'(tx), 128'(idle_blk()));
    // Push and pop together while full: push accepted, level unchanged.
    rx       = data_blk(8'h0F, 9);
    tx_ready = 1'b1;
    step();
    check("full_pushpop_level", 128'(level), 128'(8));
    check("full_pushpop_tx", 128'(tx), 128'(data_blk(8'h0F, 0)));
    check("full_pushpop_ovf", 128'(ovf_cnt), 128'(1));
    rx_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("drain%0d", k), 128'(tx), 128'(data_blk(8'h0F, (k == 8) ? 9 : k)));
    end
    check("drain_level", 128'(level), 128'(0));

    // Underrun, late term in DROP_S, then a start arriving inside an open frame.
    do_reset();
    e     = start_blk(8'h32);
    e.err = 1'b1;
    ur[0]  = '{1'b1, 1'b1, start_blk(8'h25),   idle_blk(),          4'd1};
    ur[1]  = '{1'b1, 1'b1, data_blk(8'h25, 0), start_blk(8'h25),    4'd1};
    ur[2]  = '{1'b1, 1'b1, data_blk(8'h25, 1), data_blk(8'h25, 0),  4'd1};
    ur[3]  = '{1'b0, 1'b1, blk_t'('0),         data_blk(8'h25, 1),  4'd0};
    ur[4]  = '{1'b0, 1'b1, blk_t'('0),         err_blk(),           4'd0};
    ur[5]  = '{1'b0, 1'b1, blk_t'('0),         idle_blk(),          4'd0};
    ur[6]  = '{1'b1, 1'b1, term_blk(8'h25),    idle_blk(),          4'd1};
    ur[7]  = '{1'b0, 1'b1, blk_t'('0),         idle_blk(),          4'd0};
    ur[8]  = '{1'b0, 1'b1, blk_t'('0),         idle_blk(),          4'd0};
    ur[9]  = '{1'b1, 1'b1, start_blk(8'h31),   idle_blk(),          4'd1};
    ur[10] = '{1'b1, 1'b1, start_blk(8'h32),   start_blk(8'h31),    4'd1};
    ur[11] = '{1'b0, 1'b1, blk_t'('0),         e,                   4'd0};
    ur[12] = '{1'b0, 1'b1, blk_t'('0),         err_blk(),           4'd0};
    for (int i = 0; i < 13; i++) begin
      apply(ur[i], $sformatf("ur%0d", i));
      if (i == 4) begin
        check("ur_unf_cnt", 128'(unf_cnt), 128'(1));
        check("ur_unf_sticky", 128'(unf_sticky), 128'(1));
      end
      if (i == 7) check("ur_drop_no_ins", 128'(idle_ins_cnt), 128'(0));
      if (i == 8) check("ur_back_to_idle", 128'(idle_ins_cnt), 128'(1));
    end
    check("ur_unf_cnt2", 128'(unf_cnt), 128'(2));

    // Saturation: twenty idle insertions on a 4-bit counter.
    do_reset();
    tx_ready = 1'b1;
    repeat (21) step();
    check("sat_idle_ins", 128'(idle_ins_cnt), 128'(15));
    check("sat_unf", 128'(unf_cnt), 128'(0));

    // Reset asserted mid-frame with five entries queued.
    rx_valid = 1'b1;
    tx_ready = 1'b0;
    rx       = start_blk(8'h77);
    step();
    tx_ready = 1'b1;
    rx       = data_blk(8'h77, 0);
    step();
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rx = data_blk(8'h77, i);
      step();
    end
    check("mid_level", 128'(level), 128'(5));
    check("mid_tx", 128'(tx), 128'(start_blk(8'h77)));
    #2;
    nreset = 1'b0;
    #1;
    check("rst_level", 128'(level), 128'(0));
    check("rst_tx", 128'(tx), 128'(idle_blk()));
    check_counters("rst", 0, 0, 0, 0);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    step();
    step();
    check("post_rst_tx", 128'(tx), 128'(idle_blk()));
    check("post_rst_ins", 128'(idle_ins_cnt), 128'(1));
    check("post_rst_unf", 128'(unf_cnt), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
